// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with the ALU operation decoded from the opcode and function fields.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1;
      end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_MEMREAD:  begin c.result_src = 2'b00; c.adr_src = 1'b1; end
      S_MEMWRITE: begin c.result_src = 2'b00; c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_ALUWB:    begin c.result_src = 2'b00; c.reg_write = 1'b1; end
      S_EXECUTER: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
      S_JAL: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.result_src = 2'b00; c.pc_update = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_op = 2'b01; c.branch = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // op[5] distinguishes R-type from I-ALU, so addi never turns into a subtract.
  function automatic logic [2:0] alu_decode(input logic [1:0] alu_op, input logic [2:0] f3,
                                            input logic op5, input logic f7b5);
    logic [2:0] r;
    r = 3'b000;
    case (alu_op)
      2'b01: r = 3'b001;
      2'b10: begin
        case (f3)
          3'b000:  r = (op5 & f7b5) ? 3'b001 : 3'b000;
          3'b010:  r = 3'b101;
          3'b110:  r = 3'b011;
          3'b111:  r = 3'b010;
          default: r = 3'b000;
        endcase
      end
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  state_t state_q;
  state_t state_nxt;
  ctrl_t  ctrl_q;

  always_comb begin
    state_nxt = S_FETCH;
    case (state_q)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BEQ:       state_nxt = S_BEQ;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state, precomputed from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH);
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= ctrl_for(state_nxt);
    end
  end

  assign pc_write    = ctrl_q.pc_update | (ctrl_q.branch & zero);
  assign adr_src     = ctrl_q.adr_src;
  assign mem_write   = ctrl_q.mem_write;
  assign ir_write    = ctrl_q.ir_write;
  assign reg_write   = ctrl_q.reg_write;
  assign result_src  = ctrl_q.result_src;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_control = alu_decode(ctrl_q.alu_op, funct3, op[5], funct7b5);
  assign state       = state_q;

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control unit for the multicycle RISC-V datapath. It is the producer side of the ALU interface: it generates `alu_control` in the ALU's 3-bit encoding, consumes the ALU `zero` flag, and sequences fetch, decode, execute, memory and writeback over several cycles per instruction. It sits between the instruction register (opcode and function fields) and the datapath mux, enable and write controls.

## Interface
Parameters: none. Opcode and ALU encodings are fixed.

- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; forces state FETCH.
- `op` input 7: opcode from the instruction register.
- `funct3` input 3: instruction bits [14:12].
- `funct7b5` input 1: instruction bit 30.
- `zero` input 1: ALU zero flag.
- `pc_write` output 1: PC register enable.
- `adr_src` output 1: memory address select; 0 = PC, 1 = ALU result register.
- `mem_write` output 1: data memory write enable.
- `ir_write` output 1: instruction register and old-PC enable.
- `reg_write` output 1: register file write enable.
- `result_src` output 2: result mux; 00 = ALUOut, 01 = Data, 10 = ALU result.
- `alu_src_a` output 2: ALU A mux; 00 = PC, 01 = OldPC, 10 = rs1 register.
- `alu_src_b` output 2: ALU B mux; 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `imm_src` output 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` output 3: ALU operation; 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
- `state` output 4: current state code, for debug and verification.

## Operation
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I-ALU), JAL (jal), BEQ (beq); any other opcode → FETCH (treated as a no-op).
  - MEMADR → MEMREAD if op = lw, otherwise MEMWRITE.
  - MEMREAD → MEMWB → FETCH. MEMWRITE → FETCH.
  - EXECUTER, EXECUTEI and JAL → ALUWB. ALUWB → FETCH. BEQ → FETCH.
  - Codes 11–15 → FETCH.
- Moore outputs per state; any signal not listed is 0. Internal `alu_op`: 00 = add, 01 = sub, 10 = decode from funct fields.
  - FETCH: adr_src 0, ir_write 1, src_a 00, src_b 10, alu_op 00, result_src 10, pc_update 1.
  - DECODE: src_a 01, src_b 01, alu_op 00.
  - MEMADR and EXECUTEI: src_a 10, src_b 01. alu_op is 00 in MEMADR and 10 in EXECUTEI.
  - MEMREAD: result_src 00, adr_src 1. MEMWRITE: result_src 00, adr_src 1, mem_write 1.
  - MEMWB: result_src 01, reg_write 1. ALUWB: result_src 00, reg_write 1.
  - EXECUTER: src_a 10, src_b 00, alu_op 10.
  - JAL: src_a 01, src_b 10, alu_op 00, result_src 00, pc_update 1.
  - BEQ: src_a 10, src_b 00, alu_op 01, result_src 00, branch 1.
- `pc_write` = pc_update | (branch & zero). This is the only output that depends combinationally on an input besides `op` and `funct`.
- ALU decode, purely combinational:
  - alu_op 00 → 000; alu_op 01 → 001.
  - alu_op 10 with funct3 000 → 001 if (op[5] & funct7b5), else 000. This means addi never subtracts.
  - funct3 010 → 101; funct3 110 → 011; funct3 111 → 010; any other funct3 → 000.
  - alu_op 11 → 000.
- `imm_src` is combinational from `op`: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.

## Timing
- Reset: asynchronous assertion forces FETCH immediately, including mid-instruction; the instruction in progress is abandoned. Outputs during reset equal the FETCH values: pc_write 1, ir_write 1, adr_src 0, mem_write 0, reg_write 0, result_src 10, alu_src_a 00, alu_src_b 10, alu_control 000, state 0. The first FETCH edge occurs at the first rising `clk` after deassertion.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal opcode 2.
- `op`, `funct3` and `funct7b5` must be stable from DECODE until the return to FETCH; they are sampled every cycle and not latched.
- `zero` is sampled combinationally in BEQ only. It has no effect in any other state.

## Test plan
- Reset, then hold op = 0110011, funct3 000, funct7b5 1 → state 0,1,6,7,0; alu_control 001 in EXECUTER; reg_write 1 only in ALUWB.
- op lw (0000011) → state 0,1,2,3,4,0; adr_src 1 in MEMREAD; result_src 01 and reg_write 1 in MEMWB; imm_src 00.
- op sw (0100011) → state 0,1,2,5,0; mem_write 1 for exactly one cycle; imm_src 01.
- op beq with zero = 1 → pc_write 1 in BEQ, alu_control 001. Repeat with zero = 0 → pc_write 0 in BEQ.
- op 0010011, funct3 000, funct7b5 1 (addi) → alu_control 000. funct3 110 → 011; funct3 111 → 010; funct3 010 → 101.
- Assert reset in MEMREAD → state 0 before the next edge and the FETCH reset values on all outputs. Opcode 0000000 → sequence 0,1,0.
